legv8_periph_bus: RTL and testbench

Parametrised peripheral bus controller between the LEGv8 CPU core and N memory-mapped peripherals. It replaces the single `data_in` input and single `Write` strobe with address-decoded channel select, per-peripheral ready handshake, and CPU stall. It also adds a decode-error and timeout-error path that the flat interface lacked. It sits at the CPU top level, between the datapath memory port and the peripheral set.

---
 rtl/legv8_bus_pkg.sv | 24 ++
 rtl/bus_wait_timer.sv | 37 +++
 rtl/legv8_periph_bus.sv | 190 +++++++++++++++++++
 tb/tb_legv8_periph_bus.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_bus_pkg.sv
// legv8_bus_pkg
//   Shared definitions for the LEGv8 peripheral bus controller:
//   - bus_state_t : controller FSM states (IDLE / ACCESS / DONE)
//   - ERR_*       : error codes recorded for a completed access
//   - sel_width() : width of the channel index field for N peripherals
package legv8_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DECODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // A single peripheral still needs a 1-bit index field.
  function automatic int sel_width(input int n_periph);
    if (n_periph <= 1) return 1;
    return $clog2(n_periph);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// bus_wait_timer
//   Counts ACCESS cycles spent waiting for a peripheral ready.
//   Ports:
//     clock   : rising-edge clock
//     reset   : synchronous, active-high
//     clear   : synchronous clear of the count (held while not accessing)
//     enable  : count one waited cycle
//     expired : high in the cycle whose increment makes the count reach
//               TIMEOUT, so the FSM can leave ACCESS on that same edge
module bus_wait_timer
  import legv8_bus_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/legv8_periph_bus.sv
// legv8_periph_bus
//   Address-decoded bus controller between the LEGv8 datapath memory port
//   and N memory-mapped peripherals. One access at a time; the CPU is
//   stalled until the access completes (ready), times out, or fails decode.
//   Ports:
//     clock, reset          : rising-edge clock, synchronous active-high reset
//     cpu_req/cpu_write     : access request (held until cpu_stall low), 1=store
//     cpu_addr/cpu_wdata    : access address / store data
//     cpu_rdata             : registered load data
//     cpu_stall             : combinational CPU freeze
//     cpu_err               : registered error flag, valid in DONE
//     p_sel/p_write         : registered one-hot select and write strobe
//     p_addr/p_wdata        : latched address / store data
//     p_rdata/p_ready       : packed per-channel read data and ready
module legv8_periph_bus
  import legv8_bus_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 64,
  parameter int N_PERIPH = 4,
  parameter int PSEL_LSB = 12,
  parameter int TIMEOUT  = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cpu_req,
  input  logic                         cpu_write,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  output logic                         cpu_err,
  output logic [N_PERIPH-1:0]          p_sel,
  output logic                         p_write,
  output logic [ADDR_W-1:0]            p_addr,
  output logic [DATA_W-1:0]            p_wdata,
  input  logic [N_PERIPH*DATA_W-1:0]   p_rdata,
  input  logic [N_PERIPH-1:0]          p_ready
);

  localparam int               SEL_W   = sel_width(N_PERIPH);
  localparam int               SEL_W1  = SEL_W + 1;
  localparam logic [SEL_W:0]   N_LIMIT = SEL_W1'(N_PERIPH);

  bus_state_t          state;
  bus_state_t          state_nxt;

  logic [SEL_W-1:0]    req_idx;
  logic                req_valid;
  logic [N_PERIPH-1:0] req_onehot;

  logic [SEL_W-1:0]    acc_idx;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;

  logic                timer_clear;
  logic                timer_enable;
  logic                timer_expired;

  logic [1:0]          err_code;

  // Request decode: channel index field and its one-hot select.
  always_comb begin
    req_idx    = cpu_addr[PSEL_LSB +: SEL_W];
    req_valid  = ({1'b0, req_idx} < N_LIMIT);
    req_onehot = '0;
    for (int k = 0; k < N_PERIPH; k++) begin
      req_onehot[k] = (req_idx == SEL_W'(k));
    end
  end

  // Ready / read-data mux on the latched channel; other channels' ready
  // lines never reach the FSM.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < N_PERIPH; k++) begin
      if (acc_idx == SEL_W'(k)) begin
        sel_ready = p_ready[k];
        sel_rdata = p_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  bus_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state. Ready is tested before expiry so a ready arriving in
  // the final wait cycle still completes successfully.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          state_nxt = req_valid ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: begin
        if (sel_ready || timer_expired) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM outputs. The counter only runs while waiting in ACCESS and is held
  // clear everywhere else, so every access starts from zero.
  always_comb begin
    cpu_stall    = cpu_req && (state != ST_DONE);
    timer_clear  = (state != ST_ACCESS);
    timer_enable = (state == ST_ACCESS) && !sel_ready;
  end

  // Registered bus-side and CPU-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      p_sel     <= '0;
      p_write   <= 1'b0;
      p_addr    <= '0;
      p_wdata   <= '0;
      cpu_rdata <= '0;
      acc_idx   <= '0;
      err_code  <= ERR_NONE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            if (req_valid) begin
              p_sel   <= req_onehot;
              p_write <= cpu_write;
              p_addr  <= cpu_addr;
              p_wdata <= cpu_wdata;
              acc_idx <= req_idx;
            end else begin
              err_code <= ERR_DECODE;
            end
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            p_sel    <= '0;
            p_write  <= 1'b0;
            err_code <= ERR_NONE;
            if (!p_write) begin
              cpu_rdata <= sel_rdata;
            end
          end else if (timer_expired) begin
            p_sel    <= '0;
            p_write  <= 1'b0;
            err_code <= ERR_TIMEOUT;
            if (!p_write) begin
              cpu_rdata <= '0;
            end
          end
        end
        ST_DONE: begin
          err_code <= ERR_NONE;
        end
        default: begin
          err_code <= ERR_NONE;
        end
      endcase
    end
  end

  assign cpu_err = (err_code != ERR_NONE);

endmodule

// File: tb/tb_legv8_periph_bus.sv
module tb_legv8_periph_bus;

  localparam int DW  = 64;
  localparam int AW  = 64;
  localparam int NP  = 4;
  localparam int NP3 = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Main DUT (4 channels)
  logic           cpu_req, cpu_write, cpu_stall, cpu_err, p_write;
  logic [AW-1:0]  cpu_addr, p_addr;
  logic [DW-1:0]  cpu_wdata, cpu_rdata, p_wdata;
  logic [NP-1:0]  p_sel, p_ready;
  logic [NP*DW-1:0] p_rdata;

  // Second DUT (3 channels) for decode errors
  logic           c3_req, c3_write, c3_stall, c3_err, c3_p_write;
  logic [AW-1:0]  c3_addr, c3_p_addr;
  logic [DW-1:0]  c3_wdata, c3_rdata, c3_p_wdata;
  logic [NP3-1:0] c3_p_sel, c3_p_ready;
  logic [NP3*DW-1:0] c3_p_rdata;

  legv8_periph_bus #(.DATA_W(DW), .ADDR_W(AW), .N_PERIPH(NP), .PSEL_LSB(12), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err), .p_sel(p_sel), .p_write(p_write),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ready(p_ready)
  );

  legv8_periph_bus #(.DATA_W(DW), .ADDR_W(AW), .N_PERIPH(NP3), .PSEL_LSB(12), .TIMEOUT(15)) dut3 (
    .clock(clock), .reset(reset), .cpu_req(c3_req), .cpu_write(c3_write),
    .cpu_addr(c3_addr), .cpu_wdata(c3_wdata), .cpu_rdata(c3_rdata),
    .cpu_stall(c3_stall), .cpu_err(c3_err), .p_sel(c3_p_sel), .p_write(c3_p_write),
    .p_addr(c3_p_addr), .p_wdata(c3_p_wdata), .p_rdata(c3_p_rdata), .p_ready(c3_p_ready)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            stall;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Observations collected by run_access
  logic [DW-1:0] obs_rdata;
  logic          obs_err;
  int            obs_stall, obs_acc, obs_hold, obs_first, obs_last;
  bit            obs_timed_out;
  logic [NP-1:0] obs_psel_or, obs_psel_done;

  // Drives one access on the main DUT; called at a falling edge, returns at
  // the falling edge of the cycle after DONE. Ready for channel tgt rises
  // after 'delay' ACCESS cycles; 'spur' ready bits are driven throughout.
  task automatic run_access(input logic [AW-1:0] addr, input logic wr,
                            input logic [DW-1:0] wd, input int tgt,
                            input int delay, input logic [NP-1:0] spur);
    int acc;
    bit done;
    acc = 0; done = 0;
    obs_stall = 0; obs_hold = 0; obs_first = -1; obs_last = -1;
    obs_timed_out = 1; obs_psel_or = '0; obs_psel_done = '1;
    obs_rdata = 'x; obs_err = 1'bx;
    cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
    for (int c = 0; c < 64 && !done; c++) begin
      if (p_sel != '0) begin
        acc++;
        obs_psel_or |= p_sel;
        if (obs_first < 0) obs_first = cyc;
        obs_last = cyc;
        if (p_write === wr && p_addr === addr && p_wdata === wd) obs_hold++;
      end
      p_ready = spur;
      if (acc > delay) p_ready[tgt] = 1'b1;
      #1;
      if (cpu_stall === 1'b1) obs_stall++;
      else begin
        done = 1; obs_timed_out = 0;
        obs_rdata = cpu_rdata; obs_err = cpu_err; obs_psel_done = p_sel;
      end
      if (!done) @(negedge clock);
    end
    obs_acc = acc;
    cpu_req = 1'b0;
    p_ready = '0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0; p_ready = '0; p_rdata = '0;
    c3_req = 0; c3_write = 0; c3_addr = '0; c3_wdata = '0; c3_p_ready = '0; c3_p_rdata = '0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({p_sel, p_write, cpu_err, cpu_stall} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got sel=%b wr=%b err=%b stall=%b, expected all 0", p_sel, p_write, cpu_err, cpu_stall);
    end
    n_checks++;
    if (p_addr !== '0 || p_wdata !== '0 || cpu_rdata !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, expected 0", p_addr, p_wdata, cpu_rdata);
    end
    n_checks++;
    if ({c3_p_sel, c3_err, c3_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_dut3: got sel=%b err=%b rdata=%h, expected 0", c3_p_sel, c3_err, c3_rdata);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_load_min();
    exp_t e;
    p_rdata[2*DW +: DW] = 64'hDEAD_BEEF;
    exp_q.push_back('{rdata: 64'hDEAD_BEEF, err: 1'b0, stall: 2});
    run_access(64'h2008, 1'b0, '0, 2, 0, '0);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_timed_out || obs_rdata !== e.rdata || obs_err !== e.err) begin
      n_fail++; $display("FAIL load_min_result: got to=%0d rdata=%h err=%b, expected rdata=%h err=%b", obs_timed_out, obs_rdata, obs_err, e.rdata, e.err);
    end
    n_checks++;
    if (obs_stall != e.stall) begin
      n_fail++; $display("FAIL load_min_stall: got %0d, expected %0d", obs_stall, e.stall);
    end
    n_checks++;
    if (obs_psel_or !== 4'b0100 || obs_acc != 1 || obs_psel_done !== '0) begin
      n_fail++; $display("FAIL load_min_psel: got or=%b cycles=%0d done=%b, expected 0100 1 0000", obs_psel_or, obs_acc, obs_psel_done);
    end
  endtask

  task automatic test_store_wait();
    exp_t e;
    p_rdata[1*DW +: DW] = 64'h1111_2222_3333_4444;
    exp_q.push_back('{rdata: 64'hDEAD_BEEF, err: 1'b0, stall: 5});
    run_access(64'h1010, 1'b1, 64'h55, 1, 3, '0);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_timed_out || obs_rdata !== e.rdata || obs_err !== e.err) begin
      n_fail++; $display("FAIL store_result: got to=%0d rdata=%h err=%b, expected rdata=%h err=%b", obs_timed_out, obs_rdata, obs_err, e.rdata, e.err);
    end
    n_checks++;
    if (obs_stall != e.stall) begin
      n_fail++; $display("FAIL store_stall: got %0d, expected %0d", obs_stall, e.stall);
    end
    n_checks++;
    if (obs_psel_or !== 4'b0010 || obs_acc != 4 || obs_hold != 4) begin
      n_fail++; $display("FAIL store_hold: got or=%b sel_cycles=%0d stable=%0d, expected 0010 4 4", obs_psel_or, obs_acc, obs_hold);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    p_rdata[0 +: DW] = 64'hA5A5_A5A5_A5A5_A5A5;
    exp_q.push_back('{rdata: '0, err: 1'b1, stall: 16});
    run_access(64'h0040, 1'b0, '0, 0, 1000, '0);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_timed_out || obs_rdata !== e.rdata || obs_err !== e.err) begin
      n_fail++; $display("FAIL timeout_result: got to=%0d rdata=%h err=%b, expected rdata=%h err=%b", obs_timed_out, obs_rdata, obs_err, e.rdata, e.err);
    end
    n_checks++;
    if (obs_stall != e.stall || obs_acc != 15) begin
      n_fail++; $display("FAIL timeout_stall: got stall=%0d sel_cycles=%0d, expected %0d 15", obs_stall, obs_acc, e.stall);
    end
    // Ready in the last allowed cycle wins over expiry.
    p_rdata[0 +: DW] = 64'h0123_4567_89AB_CDEF;
    exp_q.push_back('{rdata: 64'h0123_4567_89AB_CDEF, err: 1'b0, stall: 16});
    run_access(64'h0040, 1'b0, '0, 0, 14, '0);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_timed_out || obs_rdata !== e.rdata || obs_err !== e.err) begin
      n_fail++; $display("FAIL timeout_edge_result: got to=%0d rdata=%h err=%b, expected rdata=%h err=%b", obs_timed_out, obs_rdata, obs_err, e.rdata, e.err);
    end
    n_checks++;
    if (obs_stall != e.stall) begin
      n_fail++; $display("FAIL timeout_edge_stall: got %0d, expected %0d", obs_stall, e.stall);
    end
  endtask

  task automatic test_decode_err();
    int stall_n;
    bit done;
    logic [NP3-1:0] sel_or;
    logic err_seen;
    stall_n = 0; done = 0; sel_or = '0; err_seen = 1'bx;
    c3_req = 1'b1; c3_write = 1'b0; c3_addr = 64'h3000;
    for (int c = 0; c < 32 && !done; c++) begin
      sel_or |= c3_p_sel;
      #1;
      if (c3_stall === 1'b1) stall_n++;
      else begin done = 1; err_seen = c3_err; end
      if (!done) @(negedge clock);
    end
    c3_req = 1'b0;
    @(negedge clock);
    sel_or |= c3_p_sel;
    n_checks++;
    if (!done || err_seen !== 1'b1) begin
      n_fail++; $display("FAIL decode_err: got done=%0d err=%b, expected done=1 err=1", done, err_seen);
    end
    n_checks++;
    if (stall_n != 1 || sel_or !== '0) begin
      n_fail++; $display("FAIL decode_stall_psel: got stall=%0d sel=%b, expected 1 000", stall_n, sel_or);
    end
    n_checks++;
    if (c3_err !== 1'b0) begin
      n_fail++; $display("FAIL decode_err_clear: got %b, expected 0", c3_err);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    p_rdata[2*DW +: DW] = 64'h0BAD_F00D;
    p_ready = '0;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 64'h2008; cpu_wdata = '0;
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (p_sel !== 4'b0100) begin
      n_fail++; $display("FAIL midrst_pre_psel: got %b, expected 0100", p_sel);
    end
    reset = 1'b1;
    @(negedge clock);
    #1;
    n_checks++;
    if (p_sel !== '0 || cpu_rdata !== '0 || cpu_err !== 1'b0 || p_write !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got sel=%b rdata=%h err=%b wr=%b, expected 0", p_sel, cpu_rdata, cpu_err, p_write);
    end
    n_checks++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL midrst_stall_idle: got %b, expected 1", cpu_stall);
    end
    reset = 1'b0; cpu_req = 1'b0;
    @(negedge clock);
    p_rdata[3*DW +: DW] = 64'hCAFE_0000_0000_CAFE;
    exp_q.push_back('{rdata: 64'hCAFE_0000_0000_CAFE, err: 1'b0, stall: 3});
    run_access(64'h3000, 1'b0, '0, 3, 1, '0);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_timed_out || obs_rdata !== e.rdata || obs_err !== e.err || obs_stall != e.stall) begin
      n_fail++; $display("FAIL midrst_fresh_load: got rdata=%h err=%b stall=%0d, expected %h %b %0d", obs_rdata, obs_err, obs_stall, e.rdata, e.err, e.stall);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int last1;
    p_rdata[0*DW +: DW] = 64'hBAD0_BAD0_BAD0_BAD0;
    p_rdata[1*DW +: DW] = 64'h1111_0000_0000_0001;
    p_rdata[3*DW +: DW] = 64'h3333_0000_0000_0003;
    exp_q.push_back('{rdata: 64'h1111_0000_0000_0001, err: 1'b0, stall: 4});
    exp_q.push_back('{rdata: 64'h3333_0000_0000_0003, err: 1'b0, stall: 2});
    run_access(64'h1000, 1'b0, '0, 1, 2, 4'b0001);
    last1 = obs_last;
    e = exp_q.pop_front();
    n_checks++;
    if (obs_timed_out || obs_rdata !== e.rdata || obs_stall != e.stall || obs_psel_or !== 4'b0010) begin
      n_fail++; $display("FAIL b2b_first: got rdata=%h stall=%0d sel=%b, expected %h %0d 0010", obs_rdata, obs_stall, obs_psel_or, e.rdata, e.stall);
    end
    run_access(64'h3010, 1'b0, '0, 3, 0, '0);
    e = exp_q.pop_front();
    n_checks++;
    if (obs_timed_out || obs_rdata !== e.rdata || obs_err !== e.err || obs_stall != e.stall) begin
      n_fail++; $display("FAIL b2b_second: got rdata=%h err=%b stall=%0d, expected %h %b %0d", obs_rdata, obs_err, obs_stall, e.rdata, e.err, e.stall);
    end
    n_checks++;
    if (obs_first - last1 != 3) begin
      n_fail++; $display("FAIL b2b_gap: got %0d cycles between selects, expected 3", obs_first - last1);
    end
  endtask

  initial begin
    test_reset();
    test_load_min();
    test_store_wait();
    test_timeout();
    test_decode_err();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
